// File: rtl/mc_main_controller.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback steps and decodes the datapath selects and write strobes.
module mc_main_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_iord,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_regwrite,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_aluop,
    output logic [1:0] o_pcsrc,
    output logic       o_pcen,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t state;
    state_t state_next;
    logic   pcwrite;
    logic   branch;

    // Memory handshake: the controller holds the address select (and write
    // strobe for stores) steady every cycle of an access; the access completes
    // in the cycle i_mem_ready is 1, and only then does the FSM advance.

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        o_iord     = 1'b0;
        o_memwrite = 1'b0;
        o_irwrite  = 1'b0;
        o_regdst   = 1'b0;
        o_memtoreg = 1'b0;
        o_regwrite = 1'b0;
        o_alusrca  = 1'b0;
        o_alusrcb  = 2'b00;
        o_aluop    = 2'b00;
        o_pcsrc    = 2'b00;
        o_illegal  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;

        case (state)
            FETCH: begin
                o_alusrcb  = 2'b01;
                o_irwrite  = i_mem_ready;
                pcwrite    = i_mem_ready;
                state_next = i_mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is computed here, before the opcode is known.
                o_alusrcb = 2'b11;
                case (i_opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_J:         state_next = JUMP;
                    default: begin
                        o_illegal  = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                o_alusrca  = 1'b1;
                o_alusrcb  = 2'b10;
                state_next = (i_opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                o_iord     = 1'b1;
                state_next = i_mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
                state_next = i_mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                o_alusrca  = 1'b1;
                o_aluop    = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                o_alusrca  = 1'b1;
                o_aluop    = 2'b01;
                o_pcsrc    = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ADDIEXEC: begin
                o_alusrca  = 1'b1;
                o_alusrcb  = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                o_regwrite = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                o_pcsrc    = 2'b10;
                pcwrite    = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    assign o_pcen  = pcwrite | (branch & i_zero);
    assign o_state = state;

endmodule

// File: tb/tb_mc_main_controller.sv
// Randomized bench for mc_main_controller: the driver walks each instruction's
// step list and queues the expected outputs; a negedge monitor compares them.
module tb_mc_main_controller;

    localparam int W = 19;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    logic       i_clk;
    logic       i_rst_n;
    logic [5:0] i_opcode;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_iord;
    logic       o_memwrite;
    logic       o_irwrite;
    logic       o_regdst;
    logic       o_memtoreg;
    logic       o_regwrite;
    logic       o_alusrca;
    logic [1:0] o_alusrcb;
    logic [1:0] o_aluop;
    logic [1:0] o_pcsrc;
    logic       o_pcen;
    logic       o_illegal;
    logic [3:0] o_state;

    logic [W-1:0] act_vec;
    logic [W-1:0] exp_q[$];
    logic [5:0]   cur_op;
    int           checks = 0;
    int           errors = 0;

    mc_main_controller dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_opcode    (i_opcode),
        .i_zero      (i_zero),
        .i_mem_ready (i_mem_ready),
        .o_iord      (o_iord),
        .o_memwrite  (o_memwrite),
        .o_irwrite   (o_irwrite),
        .o_regdst    (o_regdst),
        .o_memtoreg  (o_memtoreg),
        .o_regwrite  (o_regwrite),
        .o_alusrca   (o_alusrca),
        .o_alusrcb   (o_alusrcb),
        .o_aluop     (o_aluop),
        .o_pcsrc     (o_pcsrc),
        .o_pcen      (o_pcen),
        .o_illegal   (o_illegal),
        .o_state     (o_state)
    );

    assign act_vec = {o_state, o_iord, o_memwrite, o_irwrite, o_regdst, o_memtoreg,
                      o_regwrite, o_alusrca, o_alusrcb, o_aluop, o_pcsrc, o_pcen, o_illegal};

    // ---------------- clock ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- reference model ----------------
    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // Expected outputs for one step, described signal by signal as the set of
    // steps in which each control is active.
    function automatic logic [W-1:0] exp_vec(input logic [3:0] ph, input logic [5:0] op,
                                             input logic rdy, input logic z);
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
        logic [1:0] alusrcb, aluop, pcsrc;
        iord     = (ph == S_MEMRD) || (ph == S_MEMWR);
        memwrite = (ph == S_MEMWR);
        irwrite  = (ph == S_FETCH) && rdy;
        regdst   = (ph == S_ALUWB);
        memtoreg = (ph == S_MEMWB);
        regwrite = (ph == S_MEMWB) || (ph == S_ALUWB) || (ph == S_ADDIWB);
        alusrca  = (ph == S_MEMADR) || (ph == S_EXECUTE) || (ph == S_BRANCH) || (ph == S_ADDIEXEC);
        alusrcb  = (ph == S_FETCH) ? 2'b01 :
                   (ph == S_DECODE) ? 2'b11 :
                   ((ph == S_MEMADR) || (ph == S_ADDIEXEC)) ? 2'b10 : 2'b00;
        aluop    = (ph == S_EXECUTE) ? 2'b10 : (ph == S_BRANCH) ? 2'b01 : 2'b00;
        pcsrc    = (ph == S_BRANCH) ? 2'b01 : (ph == S_JUMP) ? 2'b10 : 2'b00;
        pcen     = ((ph == S_FETCH) && rdy) || ((ph == S_BRANCH) && z) || (ph == S_JUMP);
        illegal  = (ph == S_DECODE) && !is_legal(op);
        return {ph, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, pcen, illegal};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (state act=%0d exp=%0d) t=%0t",
                     name, act, exp, act[W-1:W-4], exp[W-1:W-4], $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        logic [W-1:0] e;
        if (i_rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cycle_st%0d", e[W-1:W-4]), act_vec, e);
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic [3:0] ph, input logic rdy, input logic z);
        i_opcode    = cur_op;
        i_mem_ready = rdy;
        i_zero      = z;
        exp_q.push_back(exp_vec(ph, cur_op, rdy, z));
        @(posedge i_clk);
        #1;
    endtask

    // One instruction: fw fetch stalls, mw memory stalls, z is the branch zero flag.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        cur_op = op;
        repeat (fw) cyc(S_FETCH, 1'b0, rb());
        cyc(S_FETCH, 1'b1, rb());
        cyc(S_DECODE, rb(), rb());
        case (op)
            OP_LW: begin
                cyc(S_MEMADR, rb(), rb());
                repeat (mw) cyc(S_MEMRD, 1'b0, rb());
                cyc(S_MEMRD, 1'b1, rb());
                cyc(S_MEMWB, rb(), rb());
            end
            OP_SW: begin
                cyc(S_MEMADR, rb(), rb());
                repeat (mw) cyc(S_MEMWR, 1'b0, rb());
                cyc(S_MEMWR, 1'b1, rb());
            end
            OP_RTYPE: begin
                cyc(S_EXECUTE, rb(), rb());
                cyc(S_ALUWB, rb(), rb());
            end
            OP_BEQ:  cyc(S_BRANCH, rb(), z);
            OP_ADDI: begin
                cyc(S_ADDIEXEC, rb(), rb());
                cyc(S_ADDIWB, rb(), rb());
            end
            OP_J:    cyc(S_JUMP, rb(), rb());
            default: ;
        endcase
    endtask

    logic [5:0] legal_ops[6];

    initial begin
        logic [5:0] op;
        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        i_rst_n     = 1'b0;
        i_opcode    = 6'd0;
        i_zero      = 1'b0;
        i_mem_ready = 1'b0;
        cur_op      = 6'd0;

        // Reset: outputs follow the FETCH decode, pcen/irwrite track ready.
        #3;
        check("reset_rdy0", act_vec, exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0));
        i_mem_ready = 1'b1;
        #1;
        check("reset_rdy1", act_vec, exp_vec(S_FETCH, 6'd0, 1'b1, 1'b0));
        i_mem_ready = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed instructions.
        run_instr(OP_LW, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 3, 1'b0);
        run_instr(OP_RTYPE, 0, 0, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(OP_ADDI, 2, 0, 1'b0);
        run_instr(OP_LW, 1, 2, 1'b0);

        // Reset asserted in the middle of MEMRD takes effect without a clock edge.
        cur_op = OP_LW;
        cyc(S_FETCH, 1'b1, 1'b0);
        cyc(S_DECODE, 1'b1, 1'b0);
        cyc(S_MEMADR, 1'b1, 1'b0);
        i_mem_ready = 1'b0;
        exp_q.push_back(exp_vec(S_MEMRD, OP_LW, 1'b0, 1'b0));
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_async", act_vec, exp_vec(S_FETCH, OP_LW, 1'b0, 1'b0));
        i_mem_ready = 1'b1;
        #1;
        check("rst_rdy1", act_vec, exp_vec(S_FETCH, OP_LW, 1'b1, 1'b0));
        i_mem_ready = 1'b0;
        @(posedge i_clk);
        #1;
        check("rst_held", act_vec, exp_vec(S_FETCH, OP_LW, 1'b0, 1'b0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else                           op = legal_ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        cur_op = 6'd0;
        cyc(S_FETCH, 1'b0, 1'b0);
        @(negedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
